// File: rtl/pwm_arb_pkg.sv
// Shared types and constants for the PWM register-bus arbiter.
package pwm_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_RECOVER = 2'd2
   } arb_state_e;

   typedef enum logic {
      MST_0 = 1'b0,
      MST_1 = 1'b1
   } mst_id_e;

   localparam logic [2:0] BLK_GLBL = 3'd0;
   localparam logic [2:0] BLK_PWM0 = 3'd1;
   localparam logic [2:0] BLK_PWM1 = 3'd2;
   localparam logic [2:0] BLK_PWM2 = 3'd3;

   function automatic logic is_pwm_blk(input logic [2:0] blk);
      return (blk == BLK_PWM0) || (blk == BLK_PWM1) || (blk == BLK_PWM2);
   endfunction

endpackage

// File: rtl/pwm_arb_tmo.sv
// Loadable saturating down-counter; done flags terminal count (zero).
module pwm_arb_tmo #(
   parameter int W = 12
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (en && (cnt != '0))
         cnt <= cnt - 1'b1;
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/pwm_reg_arb.sv
// Two-master arbiter for the PWM register port with period-synchronised
// master-1 writes and a hung-slave access timeout.
//
//   state      | meaning
//   -----------+--------------------------------------------------
//   ST_IDLE    | no access open; arbitrate and arm master-1 sync
//   ST_ACCESS  | s_reg_cs high, waiting for slave ack or timeout
//   ST_RECOVER | one forced idle cycle on the slave bus
module pwm_reg_arb
   import pwm_arb_pkg::*;
#(
   parameter int TMO_CYC  = 64,
   parameter int SYNC_CYC = 4096
) (
   input  logic        mclk,
   input  logic        h_reset,
   input  logic        m0_cs,
   input  logic        m0_wr,
   input  logic [4:0]  m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_be,
   output logic [31:0] m0_rdata,
   output logic        m0_ack,
   input  logic        m1_cs,
   input  logic        m1_wr,
   input  logic [4:0]  m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_be,
   output logic [31:0] m1_rdata,
   output logic        m1_ack,
   input  logic        m1_sync,
   input  logic [2:0]  prd_end,
   output logic        s_reg_cs,
   output logic        s_reg_wr,
   output logic [4:0]  s_reg_addr,
   output logic [31:0] s_reg_wdata,
   output logic [3:0]  s_reg_be,
   input  logic [31:0] s_reg_rdata,
   input  logic        s_reg_ack,
   output logic        arb_tmo,
   output logic        sync_miss
);

   localparam int TMO_W  = $clog2(TMO_CYC + 1);
   localparam int SYNC_W = $clog2(SYNC_CYC + 1);
   localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(TMO_CYC - 1);
   localparam logic [SYNC_W-1:0] SYNC_LOAD = SYNC_W'(SYNC_CYC - 1);

   arb_state_e state, state_nxt;
   mst_id_e    gnt, gnt_nxt, last_gnt;
   logic       grant;
   logic       m1_wait, m1_hit;
   logic [1:0] sync_ch;
   logic       m1_syncreq, m0_elig, m1_elig, m1_arm;
   logic       prd_hit, sync_expire;
   logic       tmo_done, sync_done;
   logic       live, in_access, m0_sel, m1_sel;

   assign m1_syncreq  = m1_cs && m1_sync && is_pwm_blk(m1_addr[4:2]);
   assign m0_elig     = m0_cs;
   assign m1_elig     = m1_cs && !m1_syncreq;
   assign m1_arm      = (state == ST_IDLE) && m1_syncreq && !m1_wait && !m1_hit;
   assign prd_hit     = m1_wait && prd_end[sync_ch];
   assign sync_expire = m1_wait && sync_done;

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      gnt_nxt   = gnt;
      unique case (state)
         ST_IDLE: begin
            if (m1_hit) begin
               grant   = 1'b1;
               gnt_nxt = MST_1;
            end else if (m0_elig && m1_elig) begin
               grant   = 1'b1;
               gnt_nxt = (last_gnt == MST_1) ? MST_0 : MST_1;
            end else if (m0_elig) begin
               grant   = 1'b1;
               gnt_nxt = MST_0;
            end else if (m1_elig) begin
               grant   = 1'b1;
               gnt_nxt = MST_1;
            end
            if (grant)
               state_nxt = ST_ACCESS;
         end
         ST_ACCESS:  if (s_reg_ack || tmo_done) state_nxt = ST_RECOVER;
         ST_RECOVER: state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge mclk) begin
      if (h_reset) begin
         state       <= ST_IDLE;
         gnt         <= MST_0;
         last_gnt    <= MST_1;
         m1_wait     <= 1'b0;
         m1_hit      <= 1'b0;
         sync_ch     <= 2'd0;
         s_reg_cs    <= 1'b0;
         s_reg_wr    <= 1'b0;
         s_reg_addr  <= '0;
         s_reg_wdata <= '0;
         s_reg_be    <= '0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            gnt         <= gnt_nxt;
            last_gnt    <= gnt_nxt;
            s_reg_cs    <= 1'b1;
            s_reg_wr    <= (gnt_nxt == MST_1) ? m1_wr    : m0_wr;
            s_reg_addr  <= (gnt_nxt == MST_1) ? m1_addr  : m0_addr;
            s_reg_wdata <= (gnt_nxt == MST_1) ? m1_wdata : m0_wdata;
            s_reg_be    <= (gnt_nxt == MST_1) ? m1_be    : m0_be;
         end else if (state_nxt == ST_RECOVER) begin
            s_reg_cs <= 1'b0;
         end
         // A boundary or expiry hands the request over from wait to hit.
         if (grant && (gnt_nxt == MST_1)) begin
            m1_wait <= 1'b0;
            m1_hit  <= 1'b0;
         end else if (m1_arm) begin
            m1_wait <= 1'b1;
            sync_ch <= 2'(m1_addr[4:2] - 3'd1);
         end else if (prd_hit || sync_expire) begin
            m1_wait <= 1'b0;
            m1_hit  <= 1'b1;
         end
      end
   end

   pwm_arb_tmo #(.W(TMO_W)) u_tmo_acc (
      .clk      (mclk),
      .rst      (h_reset),
      .load     (grant),
      .en       (state == ST_ACCESS),
      .load_val (TMO_LOAD),
      .done     (tmo_done)
   );

   pwm_arb_tmo #(.W(SYNC_W)) u_tmo_sync (
      .clk      (mclk),
      .rst      (h_reset),
      .load     (m1_arm),
      .en       (m1_wait),
      .load_val (SYNC_LOAD),
      .done     (sync_done)
   );

   // Responses are masked during reset so an aborted access never acks.
   assign live      = !h_reset;
   assign in_access = live && (state == ST_ACCESS);
   assign m0_sel    = in_access && (gnt == MST_0);
   assign m1_sel    = in_access && (gnt == MST_1);

   assign m0_ack    = m0_sel && (s_reg_ack || tmo_done);
   assign m1_ack    = m1_sel && (s_reg_ack || tmo_done);
   assign m0_rdata  = (m0_sel && s_reg_ack) ? s_reg_rdata : '0;
   assign m1_rdata  = (m1_sel && s_reg_ack) ? s_reg_rdata : '0;
   assign arb_tmo   = in_access && tmo_done && !s_reg_ack;
   assign sync_miss = live && sync_expire && !prd_hit;

endmodule

// File: tb/tb_pwm_reg_arb.sv
// Directed self-checking bench for pwm_reg_arb with hand-computed expectations.
module tb_pwm_reg_arb;
   import pwm_arb_pkg::*;

   logic        mclk = 1'b0;
   logic        h_reset;
   logic        m0_cs, m0_wr, m1_cs, m1_wr, m1_sync;
   logic [4:0]  m0_addr, m1_addr;
   logic [31:0] m0_wdata, m1_wdata;
   logic [3:0]  m0_be, m1_be;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_ack, m1_ack;
   logic [2:0]  prd_end;
   logic        s_reg_cs, s_reg_wr;
   logic [4:0]  s_reg_addr;
   logic [31:0] s_reg_wdata;
   logic [3:0]  s_reg_be;
   logic [31:0] s_reg_rdata;
   logic        s_reg_ack;
   logic        arb_tmo, sync_miss;

   int n_chk = 0;
   int n_err = 0;
   logic early;

   always #5 mclk = ~mclk;

   pwm_reg_arb #(.TMO_CYC(64), .SYNC_CYC(4096)) dut (
      .mclk(mclk), .h_reset(h_reset),
      .m0_cs(m0_cs), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_be(m0_be), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
      .m1_cs(m1_cs), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_be(m1_be), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
      .m1_sync(m1_sync), .prd_end(prd_end),
      .s_reg_cs(s_reg_cs), .s_reg_wr(s_reg_wr), .s_reg_addr(s_reg_addr),
      .s_reg_wdata(s_reg_wdata), .s_reg_be(s_reg_be),
      .s_reg_rdata(s_reg_rdata), .s_reg_ack(s_reg_ack),
      .arb_tmo(arb_tmo), .sync_miss(sync_miss)
   );

   task automatic tick();
      @(posedge mclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for s_reg_cs, checks the granted address, acks at once
   // and releases the served master during the RECOVER cycle.
   task automatic expect_grant(input string tag, input logic exp_m1,
                               input logic [4:0] exp_addr, input logic [31:0] rd);
      int n = 0;
      while (s_reg_cs !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      chk({tag, "_cs"}, 32'(s_reg_cs), 32'd1);
      chk({tag, "_addr"}, 32'(s_reg_addr), 32'(exp_addr));
      s_reg_ack = 1'b1;
      s_reg_rdata = rd;
      #1;
      chk({tag, "_m0_ack"}, 32'(m0_ack), 32'(!exp_m1));
      chk({tag, "_m1_ack"}, 32'(m1_ack), 32'(exp_m1));
      chk({tag, "_m0_rdata"}, m0_rdata, exp_m1 ? 32'd0 : rd);
      chk({tag, "_m1_rdata"}, m1_rdata, exp_m1 ? rd : 32'd0);
      tick();
      s_reg_ack = 1'b0;
      s_reg_rdata = '0;
      if (exp_m1) begin
         m1_cs = 1'b0;
         m1_sync = 1'b0;
      end else begin
         m0_cs = 1'b0;
      end
      chk({tag, "_recover_cs"}, 32'(s_reg_cs), 32'd0);
   endtask

   initial begin
      h_reset = 1'b1;
      m0_cs = 0; m0_wr = 0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
      m1_cs = 0; m1_wr = 0; m1_addr = '0; m1_wdata = '0; m1_be = '0; m1_sync = 0;
      prd_end = '0; s_reg_rdata = '0; s_reg_ack = 0;
      tick();
      tick();
      chk("rst_cs", 32'(s_reg_cs), 32'd0);
      chk("rst_addr", 32'(s_reg_addr), 32'd0);
      chk("rst_acks", 32'({m0_ack, m1_ack, arb_tmo, sync_miss}), 32'd0);
      h_reset = 1'b0;
      tick();

      // Master-0 read of 0x04, slave acks in the third ACCESS cycle.
      m0_cs = 1; m0_wr = 0; m0_addr = 5'h04; m0_be = 4'hf;
      tick();
      chk("rd_cs1", 32'(s_reg_cs), 32'd1);
      chk("rd_addr", 32'(s_reg_addr), 32'h04);
      chk("rd_wr", 32'(s_reg_wr), 32'd0);
      chk("rd_noack1", 32'(m0_ack), 32'd0);
      tick();
      chk("rd_cs2", 32'(s_reg_cs), 32'd1);
      tick();
      chk("rd_cs3", 32'(s_reg_cs), 32'd1);
      s_reg_ack = 1; s_reg_rdata = 32'h1234;
      #1;
      chk("rd_ack", 32'(m0_ack), 32'd1);
      chk("rd_data", m0_rdata, 32'h1234);
      chk("rd_m1_quiet", {31'd0, m1_ack} | m1_rdata, 32'd0);
      tick();
      s_reg_ack = 0; s_reg_rdata = '0; m0_cs = 0;
      chk("rd_cs_drop", 32'(s_reg_cs), 32'd0);
      chk("rd_ack_pulse", 32'(m0_ack), 32'd0);
      tick();

      // Round robin from reset: m0, m1, m0, m1.
      h_reset = 1; tick(); h_reset = 0; tick();
      m0_cs = 1; m0_wr = 0; m0_addr = 5'h00;
      m1_cs = 1; m1_wr = 1; m1_addr = 5'h1c; m1_wdata = 32'ha5a5a5a5; m1_be = 4'h3; m1_sync = 0;
      expect_grant("rr0", 1'b0, 5'h00, 32'h11);
      expect_grant("rr1", 1'b1, 5'h1c, 32'h22);
      m0_cs = 1; m0_addr = 5'h01;
      m1_cs = 1; m1_addr = 5'h1d;
      expect_grant("rr2", 1'b0, 5'h01, 32'h33);
      expect_grant("rr3", 1'b1, 5'h1d, 32'h44);
      tick();

      // Synchronised master-1 write to PWM1 (channel 1).
      m1_cs = 1; m1_wr = 1; m1_addr = 5'h08; m1_wdata = 32'hdead_beef; m1_be = 4'hf; m1_sync = 1;
      tick();
      tick();
      chk("sync_not_granted", 32'(s_reg_cs), 32'd0);
      chk("sync_armed", 32'(dut.m1_wait), 32'd1);
      m0_cs = 1; m0_wr = 0; m0_addr = 5'h03;
      expect_grant("sync_m0_first", 1'b0, 5'h03, 32'h55);
      prd_end = 3'b001;
      tick();
      prd_end = 3'b000;
      tick();
      tick();
      chk("sync_wrong_ch", 32'(s_reg_cs), 32'd0);
      prd_end = 3'b010;
      tick();
      prd_end = 3'b000;
      chk("sync_cs_lat1", 32'(s_reg_cs), 32'd0);
      tick();
      chk("sync_cs_lat2", 32'(s_reg_cs), 32'd1);
      chk("sync_wr", 32'(s_reg_wr), 32'd1);
      chk("sync_wdata", s_reg_wdata, 32'hdead_beef);
      expect_grant("sync_m1", 1'b1, 5'h08, 32'h66);
      tick();

      // Hung slave: forced completion in the 64th ACCESS cycle.
      m0_cs = 1; m0_wr = 1; m0_addr = 5'h05; m0_wdata = 32'h77; s_reg_rdata = 32'hbad0bad0;
      tick();
      chk("tmo_cs", 32'(s_reg_cs), 32'd1);
      early = 0;
      for (int i = 1; i < 64; i++) begin
         if (m0_ack || arb_tmo) early = 1;
         tick();
      end
      chk("tmo_early", 32'(early), 32'd0);
      chk("tmo_ack", 32'(m0_ack), 32'd1);
      chk("tmo_flag", 32'(arb_tmo), 32'd1);
      chk("tmo_rdata", m0_rdata, 32'd0);
      tick();
      m0_cs = 0;
      chk("tmo_cs_drop", 32'(s_reg_cs), 32'd0);
      chk("tmo_pulse", 32'({m0_ack, arb_tmo}), 32'd0);
      tick();
      chk("tmo_idle", 32'(dut.state), 32'(ST_IDLE));

      // Ack arriving in the timeout cycle wins.
      m0_cs = 1;
      tick();
      early = 0;
      for (int i = 1; i < 64; i++) begin
         if (m0_ack || arb_tmo) early = 1;
         tick();
      end
      s_reg_ack = 1; s_reg_rdata = 32'h5a5a;
      #1;
      chk("tmo_race_early", 32'(early), 32'd0);
      chk("tmo_race_ack", 32'(m0_ack), 32'd1);
      chk("tmo_race_flag", 32'(arb_tmo), 32'd0);
      chk("tmo_race_rdata", m0_rdata, 32'h5a5a);
      tick();
      s_reg_ack = 0; s_reg_rdata = '0; m0_cs = 0;
      tick();

      // Sync expiry on channel 2 with no period end.
      m1_cs = 1; m1_wr = 0; m1_addr = 5'h0c; m1_sync = 1;
      tick();
      early = 0;
      for (int i = 1; i < 4096; i++) begin
         if (sync_miss || s_reg_cs) early = 1;
         tick();
      end
      chk("miss_early", 32'(early), 32'd0);
      chk("miss_pulse", 32'(sync_miss), 32'd1);
      tick();
      chk("miss_one_cycle", 32'(sync_miss), 32'd0);
      expect_grant("miss_grant", 1'b1, 5'h0c, 32'h88);
      tick();

      // Period end coinciding with expiry suppresses sync_miss.
      m1_cs = 1; m1_wr = 0; m1_addr = 5'h04; m1_sync = 1;
      tick();
      early = 0;
      for (int i = 1; i < 4096; i++) begin
         if (sync_miss || s_reg_cs) early = 1;
         tick();
      end
      prd_end = 3'b001;
      #1;
      chk("race_early", 32'(early), 32'd0);
      chk("race_no_miss", 32'(sync_miss), 32'd0);
      tick();
      prd_end = 3'b000;
      expect_grant("race_grant", 1'b1, 5'h04, 32'h99);
      tick();

      // Reset during an m0 access while m1 waits for a boundary.
      m1_cs = 1; m1_wr = 1; m1_addr = 5'h04; m1_sync = 1;
      tick();
      m0_cs = 1; m0_wr = 0; m0_addr = 5'h02;
      tick();
      chk("rst_mid_cs", 32'(s_reg_cs), 32'd1);
      chk("rst_mid_wait", 32'(dut.m1_wait), 32'd1);
      h_reset = 1;
      #1;
      chk("rst_mid_noack", 32'({m0_ack, m1_ack}), 32'd0);
      tick();
      chk("rst_mid_cs_drop", 32'(s_reg_cs), 32'd0);
      chk("rst_mid_wait_clr", 32'(dut.m1_wait), 32'd0);
      chk("rst_mid_state", 32'(dut.state), 32'(ST_IDLE));
      chk("rst_mid_noack2", 32'({m0_ack, m1_ack}), 32'd0);
      m0_cs = 0; m1_cs = 0; m1_sync = 0;
      h_reset = 0;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
